// File: rtl/pkt_field_reader.sv
// Header-field fetcher: reads a 1..MAX_BYTES field at any byte offset through the
// mem width adapter using aligned word/half/byte loads, assembling it big-endian.
module pkt_field_reader #(
    parameter int                 MAX_BYTES    = 8,
    parameter int                 READ_LATENCY = 1,
    parameter int                 ADDR_W       = 32,
    parameter int                 DATA_W       = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      offset_i,
    input  logic [3:0]             len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [8*MAX_BYTES-1:0] field_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [3:0]             mem_width_o,
    output logic [DATA_W-1:0]      mem_data_o,
    input  logic [DATA_W-1:0]      mem_data_i
);

    localparam int FW = 8 * MAX_BYTES;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [3:0]        rem;
    logic [FW-1:0]     acc;
    logic [CW-1:0]     wait_cnt;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [3:0]        next_rem;
    logic [FW-1:0]     acc_merged;
    logic              bad_len;

    // Largest naturally aligned load that fits in the remaining bytes; never crosses a word.
    function automatic logic [3:0] sel_width(input logic [ADDR_W-1:0] a, input logic [3:0] r);
        if (a[1:0] == 2'b00 && r >= 4'd4)
            return 4'd4;
        else if (a[0] == 1'b0 && r >= 4'd2)
            return 4'd2;
        else
            return 4'd1;
    endfunction

    function automatic logic [FW-1:0] merge(input logic [FW-1:0] a, input logic [3:0] w,
                                            input logic [DATA_W-1:0] d);
        case (w)
            4'd4:    return (a << 32) | FW'(d[31:0]);
            4'd2:    return (a << 16) | FW'(d[15:0]);
            default: return (a << 8)  | FW'(d[7:0]);
        endcase
    endfunction

    assign start_addr = BASE_ADDR + offset_i;
    assign next_addr  = mem_addr_o + ADDR_W'(mem_width_o);
    assign next_rem   = rem - mem_width_o;
    assign acc_merged = merge(acc, mem_width_o, mem_data_i);
    assign bad_len    = (len_i == 4'd0) || (32'(len_i) > MAX_BYTES);

    // Load-only initiator: the write side of the adapter is tied off.
    assign mem_we_o   = 1'b0;
    assign mem_data_o = '0;

    // NOTE: every register here uses <= so all state updates see pre-edge values;
    // blocking assignments would make the outcome depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            field_o     <= '0;
            mem_ce_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_width_o <= 4'd0;
            rem         <= 4'd0;
            acc         <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        acc    <= '0;
                        if (bad_len) begin
                            err_o   <= 1'b1;
                            done_o  <= 1'b1;
                            field_o <= '0;
                            state   <= S_DONE;
                        end else begin
                            mem_ce_o    <= 1'b1;
                            mem_addr_o  <= start_addr;
                            mem_width_o <= sel_width(start_addr, len_i);
                            rem         <= len_i;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        acc <= acc_merged;
                        if (next_rem == 4'd0) begin
                            mem_ce_o <= 1'b0;
                            done_o   <= 1'b1;
                            field_o  <= acc_merged;
                            state    <= S_DONE;
                        end else begin
                            mem_addr_o  <= next_addr;
                            mem_width_o <= sel_width(next_addr, next_rem);
                            rem         <= next_rem;
                            state       <= S_ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
